// File: rtl/vga_bounce_renderer.sv
// vga_bounce_renderer: two-stage pixel generator placed after the sync generator.
// Draws a white frame border, a selectable background and a bouncing square whose
// colour rotates on every bounce. Pixel and both syncs leave exactly 2 clocks after
// the raster position that produced them.
module vga_bounce_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] counter_x,
    input  logic [9:0] counter_y,
    input  logic       in_display_area,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       sw_cc,
    input  logic       move_en,
    output logic [2:0] pixel,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       frame_tick
);

    localparam logic [9:0]  H_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
    localparam logic [10:0] BOX    = 11'(BOX_SIZE);
    localparam logic [10:0] STP    = 11'(STEP);

    // Stage-1 registers
    logic [9:0] x_s1_reg, y_s1_reg;
    logic       disp_s1_reg, hs_s1_reg, vs_s1_reg;

    // Stage-2 / output registers
    logic [2:0] pixel_reg, pixel_next;
    logic       hs_s2_reg, vs_s2_reg, frame_tick_reg;

    // Box state shared by both axes
    logic [2:0] colour_reg;
    logic       sw_meta_reg, sw_sync_reg, bg_sel_reg;
    logic [1:0] in_range;
    logic [1:0] bounce;
    logic       tick_cond;
    logic       border;

    // Last visible pixel of the frame is sitting in stage 1: motion and bg_sel update here
    assign tick_cond = disp_s1_reg && (x_s1_reg == H_LAST) && (y_s1_reg == V_LAST);
    assign border    = (x_s1_reg == 10'd0) || (x_s1_reg == H_LAST) ||
                       (y_s1_reg == 10'd0) || (y_s1_reg == V_LAST);

    // Stage 1: capture raster position, display enable and syncs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_s1_reg    <= '0;
            y_s1_reg    <= '0;
            disp_s1_reg <= 1'b0;
            hs_s1_reg   <= 1'b1;
            vs_s1_reg   <= 1'b1;
        end else begin
            x_s1_reg    <= counter_x;
            y_s1_reg    <= counter_y;
            disp_s1_reg <= in_display_area;
            hs_s1_reg   <= hsync_in;
            vs_s1_reg   <= vsync_in;
        end
    end

    // Per-axis box position, direction and hit test (gi=0: X, gi=1: Y)
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic [10:0] LIMIT = (gi == 0) ? 11'(H_ACTIVE) : 11'(V_ACTIVE);
            logic [9:0]  pos_reg, pos_next;
            logic        fwd_reg, fwd_next;
            logic        bounce_next;
            logic [10:0] pos_ext, coord_ext;

            assign pos_ext      = {1'b0, pos_reg};
            assign coord_ext    = (gi == 0) ? {1'b0, x_s1_reg} : {1'b0, y_s1_reg};
            assign in_range[gi] = (coord_ext >= pos_ext) && (coord_ext < pos_ext + BOX);
            assign bounce[gi]   = bounce_next;

            // Next position: step forward/backward, clamp to the edge and reverse on bounce
            always_comb begin
                pos_next    = pos_reg;
                fwd_next    = fwd_reg;
                bounce_next = 1'b0;
                if (fwd_reg) begin
                    if (pos_ext + BOX + STP > LIMIT) begin
                        pos_next    = 10'(LIMIT - BOX);
                        fwd_next    = 1'b0;
                        bounce_next = 1'b1;
                    end else begin
                        pos_next = 10'(pos_ext + STP);
                    end
                end else begin
                    if (pos_ext < STP) begin
                        pos_next    = 10'd0;
                        fwd_next    = 1'b1;
                        bounce_next = 1'b1;
                    end else begin
                        pos_next = 10'(pos_ext - STP);
                    end
                end
            end

            // Position/direction advance once per frame when motion is enabled
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pos_reg <= '0;
                    fwd_reg <= 1'b1;
                end else if (tick_cond && move_en) begin
                    pos_reg <= pos_next;
                    fwd_reg <= fwd_next;
                end
            end
        end
    endgenerate

    // Colour rotates once per frame with any bounce (a corner counts as one)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colour_reg <= 3'b001;
        end else if (tick_cond && move_en && (|bounce)) begin
            colour_reg <= {colour_reg[1:0], colour_reg[2]};
        end
    end

    // Switch synchroniser; background only changes between frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_reg <= 1'b0;
            sw_sync_reg <= 1'b0;
            bg_sel_reg  <= 1'b0;
        end else begin
            sw_meta_reg <= sw_cc;
            sw_sync_reg <= sw_meta_reg;
            if (tick_cond) begin
                bg_sel_reg <= sw_sync_reg;
            end
        end
    end

    // Pixel priority: blanking, border, box, background
    always_comb begin
        pixel_next = 3'b000;
        if (!disp_s1_reg) begin
            pixel_next = 3'b000;
        end else if (border) begin
            pixel_next = 3'b111;
        end else if (&in_range) begin
            pixel_next = colour_reg;
        end else begin
            pixel_next = bg_sel_reg ? 3'b001 : 3'b000;
        end
    end

    // Stage 2: register pixel, forwarded syncs and frame tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_reg      <= 3'b000;
            hs_s2_reg      <= 1'b1;
            vs_s2_reg      <= 1'b1;
            frame_tick_reg <= 1'b0;
        end else begin
            pixel_reg      <= pixel_next;
            hs_s2_reg      <= hs_s1_reg;
            vs_s2_reg      <= vs_s1_reg;
            frame_tick_reg <= tick_cond;
        end
    end

    assign pixel      = pixel_reg;
    assign hsync_out  = hs_s2_reg;
    assign vsync_out  = vs_s2_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_vga_bounce_renderer.sv
// Scoreboard bench for vga_bounce_renderer: each probe pushes the expected
// {pixel, hsync, vsync, frame_tick}; a monitor pops and compares 2 clocks later.
module tb_vga_bounce_renderer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] counter_x = '0;
    logic [9:0] counter_y = '0;
    logic       in_display_area = 1'b0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic       sw_cc = 1'b0;
    logic       move_en = 1'b0;
    logic [2:0] pixel;
    logic       hsync_out, vsync_out, frame_tick;

    vga_bounce_renderer dut (
        .clk             (clk),
        .rst             (rst),
        .counter_x       (counter_x),
        .counter_y       (counter_y),
        .in_display_area (in_display_area),
        .hsync_in        (hsync_in),
        .vsync_in        (vsync_in),
        .sw_cc           (sw_cc),
        .move_en         (move_en),
        .pixel           (pixel),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out),
        .frame_tick      (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] pix;
        logic       hs;
        logic       vs;
        logic       tick;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic probe_flag = 1'b0;
    logic d1 = 1'b0, d2 = 1'b0;

    // Probe-presence pipeline mirrors the 2-clock output latency
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            d1 <= probe_flag;
            d2 <= d1;
        end
    end

    // Monitor: compare DUT outputs against the oldest expectation
    always @(negedge clk) begin
        if (!rst && d2) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_underflow: output present with empty scoreboard");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (pixel !== e.pix || hsync_out !== e.hs || vsync_out !== e.vs ||
                    frame_tick !== e.tick) begin
                    miscompares++;
                    $display("FAIL %s: got pix=%b hs=%b vs=%b tick=%b, expected pix=%b hs=%b vs=%b tick=%b",
                             e.name, pixel, hsync_out, vsync_out, frame_tick,
                             e.pix, e.hs, e.vs, e.tick);
                end else begin
                    $display("ok   %s: pix=%b hs=%b vs=%b tick=%b", e.name, pixel,
                             hsync_out, vsync_out, frame_tick);
                end
            end
        end
    end

    task automatic direct_check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic probe(input string name, input int x, input int y, input logic disp,
                         input logic hs, input logic vs, input logic [2:0] exp_pix,
                         input logic exp_tick);
        exp_t e;
        @(negedge clk);
        counter_x       = 10'(x);
        counter_y       = 10'(y);
        in_display_area = disp;
        hsync_in        = hs;
        vsync_in        = vs;
        probe_flag      = 1'b1;
        e.name = name; e.pix = exp_pix; e.hs = hs; e.vs = vs; e.tick = exp_tick;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            counter_x       = '0;
            counter_y       = '0;
            in_display_area = 1'b0;
            hsync_in        = 1'b1;
            vsync_in        = 1'b1;
            probe_flag      = 1'b0;
        end
    endtask

    // One frame end: last visible pixel, checked for border colour and a tick pulse
    task automatic tick();
        probe("frame_tick", 639, 479, 1'b1, 1'b1, 1'b1, 3'b111, 1'b1);
        idle(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset mid-line with non-idle outputs
        repeat (3) @(negedge clk);
        rst = 1'b0;
        counter_x = 10'd0; counter_y = 10'd0; in_display_area = 1'b1;
        hsync_in = 1'b0; vsync_in = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        direct_check("pre_reset_pixel", {5'd0, pixel}, 8'h07);
        direct_check("pre_reset_hsync", {7'd0, hsync_out}, 8'h00);
        rst = 1'b1;
        #1;
        direct_check("reset_pixel", {5'd0, pixel}, 8'h00);
        direct_check("reset_syncs", {6'd0, hsync_out, vsync_out}, 8'h03);
        direct_check("reset_tick", {7'd0, frame_tick}, 8'h00);
        idle(1);
        rst = 1'b0;
        idle(2);

        // First frame from reset: box (0,0), colour 001
        probe("box_5_5",     5,   5,   1'b1, 1'b1, 1'b1, 3'b001, 1'b0);
        probe("border_0_0",  0,   0,   1'b1, 1'b1, 1'b1, 3'b111, 1'b0);
        probe("bg_100_100",  100, 100, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        probe("box_31_31",   31,  31,  1'b1, 1'b1, 1'b1, 3'b001, 1'b0);
        probe("bg_32_5",     32,  5,   1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        probe("border_r",    639, 5,   1'b1, 1'b1, 1'b1, 3'b111, 1'b0);
        probe("border_b",    5,   479, 1'b1, 1'b1, 1'b1, 3'b111, 1'b0);
        probe("blank_5_5",   5,   5,   1'b0, 1'b1, 1'b1, 3'b000, 1'b0);
        // Test 2: back-to-back sync toggles must emerge in order, 2 clocks later
        probe("sync_a",      100, 100, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
        probe("sync_b",      10,  10,  1'b1, 1'b1, 1'b0, 3'b001, 1'b0);
        probe("sync_c",      0,   10,  1'b1, 1'b0, 1'b0, 3'b111, 1'b0);
        probe("sync_d",      200, 10,  1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        idle(2);

        // Test 3: one frame of motion -> box at (2,2)
        move_en = 1'b1;
        tick();
        probe("after_tick",  200, 200, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        probe("box_33_33",   33,  33,  1'b1, 1'b1, 1'b1, 3'b001, 1'b0);
        probe("bg_34_34",    34,  34,  1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        probe("bg_1_1",      1,   1,   1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        probe("box_2_2",     2,   2,   1'b1, 1'b1, 1'b1, 3'b001, 1'b0);
        idle(1);

        // Test 4: ticks 2..224 -> box (448,448)
        for (int i = 2; i <= 224; i++) tick();
        probe("t224_in",     448, 448, 1'b1, 1'b1, 1'b1, 3'b001, 1'b0);
        probe("t224_out",    447, 447, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        probe("t224_edge",   479, 470, 1'b1, 1'b1, 1'b1, 3'b001, 1'b0);
        probe("t224_past",   480, 470, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        idle(1);
        // Tick 225: Y bounce, box (450,448), colour 010
        tick();
        probe("t225_in",     450, 448, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0);
        probe("t225_left",   449, 448, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        probe("t225_far",    481, 478, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0);
        probe("t225_past",   482, 478, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        idle(1);
        // Ticks 226..305: X bounce at 305, box (608,288), colour 100
        for (int i = 226; i <= 305; i++) tick();
        probe("t305_in",     608, 288, 1'b1, 1'b1, 1'b1, 3'b100, 1'b0);
        probe("t305_far",    638, 319, 1'b1, 1'b1, 1'b1, 3'b100, 1'b0);
        probe("t305_left",   607, 288, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        probe("t305_above",  608, 287, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        probe("t305_below",  608, 320, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        idle(1);
        // Tick 306: box (606,286)
        tick();
        probe("t306_in",     606, 286, 1'b1, 1'b1, 1'b1, 3'b100, 1'b0);
        probe("t306_far",    637, 317, 1'b1, 1'b1, 1'b1, 3'b100, 1'b0);
        probe("t306_past",   638, 317, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        idle(1);

        // Test 5: hold for 3 frames, ticks still pulse
        move_en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        probe("hold_in",     606, 286, 1'b1, 1'b1, 1'b1, 3'b100, 1'b0);
        probe("hold_left",   605, 286, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        idle(1);

        // Test 6: background switch applies only from the next frame tick
        sw_cc = 1'b1;
        idle(4);
        probe("sw_pre_bg",   100, 100, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        probe("sw_pre_bdr",  0,   5,   1'b1, 1'b1, 1'b1, 3'b111, 1'b0);
        probe("sw_pre_box",  610, 290, 1'b1, 1'b1, 1'b1, 3'b100, 1'b0);
        idle(1);
        tick();
        probe("sw_post_bg",  100, 100, 1'b1, 1'b1, 1'b1, 3'b001, 1'b0);
        probe("sw_post_bdr", 0,   5,   1'b1, 1'b1, 1'b1, 3'b111, 1'b0);
        probe("sw_post_box", 610, 290, 1'b1, 1'b1, 1'b1, 3'b100, 1'b0);
        probe("sw_post_blk", 100, 100, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0);
        idle(4);

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
